// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus controller: register addresses, FSM states, defaults.
package spart_pkg;

  // SPART register map, driven on ioaddr
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // 50 MHz / (16 * 9600) - 1
  localparam logic [15:0] BAUD_DIV_DEFAULT = 16'd325;

  typedef enum logic [2:0] {
    StCfgLo,
    StCfgHi,
    StIdle,
    StRxRead,
    StTxWrite,
    StTxHold
  } state_e;

endpackage

// File: rtl/spart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be written to the SPART TX buffer.
// Depth must be a power of two so the pointers wrap naturally.
module spart_tx_fifo #(
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic [7:0]                       din,
  output logic [7:0]                       dout,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(TX_DEPTH + 1)-1:0]  count
);

  localparam int unsigned PtrW = $clog2(TX_DEPTH);
  localparam int unsigned CntW = $clog2(TX_DEPTH + 1);

  logic [7:0]      mem_q [TX_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(TX_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Occupancy follows push/pop; simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: ;
    endcase
  end

  // Pointer and occupancy state, flushed by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only slots between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spart_bus_ctrl.sv
// Sole master of the SPART processor bus: programs the baud divisor after reset, then
// services RX reads (priority) and drains the TX FIFO whenever the SPART is ready.
// Optional build macro SPART_RX_ECHO_EN: every received byte is pushed back into the TX FIFO.
module spart_bus_ctrl
  import spart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_full,
  output logic       cfg_done
);

  localparam int unsigned CntW = $clog2(TX_DEPTH + 1);

  state_e          state_q, state_d;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q, cfg_done_q;

  logic            bus_cs, bus_rw, bus_drv;
  logic [1:0]      bus_addr;
  logic [7:0]      bus_wdata;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty, echo_push;
  logic [7:0]      fifo_din, fifo_dout;
  logic [CntW-1:0] fifo_count;
  logic            unused_fifo_count;

  assign unused_fifo_count = ^fifo_count;

`ifdef SPART_RX_ECHO_EN
  // The echo owns the push slot while rx_valid is high; it is dropped if the FIFO is full
  assign echo_push = rx_valid_q && !fifo_full;
  assign tx_full   = fifo_full || rx_valid_q;
`else
  assign echo_push = 1'b0;
  assign tx_full   = fifo_full;
`endif

  assign fifo_push = (tx_req && !tx_full) || echo_push;
  assign fifo_din  = echo_push ? rx_data_q : tx_data;
  assign fifo_pop  = (state_q == StTxWrite);

  spart_tx_fifo #(
    .TX_DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Next state: RX always beats TX when leaving idle; every access lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      StCfgLo:   state_d = StCfgHi;
      StCfgHi:   state_d = StIdle;
      StIdle: begin
        if (rda)                     state_d = StRxRead;
        else if (!fifo_empty && tbr) state_d = StTxWrite;
      end
      StRxRead:  state_d = StIdle;
      StTxWrite: state_d = StTxHold;
      StTxHold:  state_d = StIdle;
      default:   state_d = StCfgLo;
    endcase
  end

  // FSM state plus registered RX capture, RX strobe and configuration flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCfgLo;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= (state_q == StRxRead);
      if (state_q == StRxRead) rx_data_q <= databus;
      if (state_q == StCfgHi)  cfg_done_q <= 1'b1;
    end
  end

  // Bus drive decoded from the current state; idle and hold leave the bus released
  always_comb begin
    bus_cs    = 1'b0;
    bus_rw    = 1'b1;
    bus_addr  = ADDR_BUF;
    bus_drv   = 1'b0;
    bus_wdata = '0;
    case (state_q)
      StCfgLo: begin
        bus_cs    = 1'b1;
        bus_rw    = 1'b0;
        bus_addr  = ADDR_DBL;
        bus_drv   = 1'b1;
        bus_wdata = BAUD_DIV[7:0];
      end
      StCfgHi: begin
        bus_cs    = 1'b1;
        bus_rw    = 1'b0;
        bus_addr  = ADDR_DBH;
        bus_drv   = 1'b1;
        bus_wdata = BAUD_DIV[15:8];
      end
      StRxRead: begin
        bus_cs = 1'b1;
      end
      StTxWrite: begin
        bus_cs    = 1'b1;
        bus_rw    = 1'b0;
        bus_drv   = 1'b1;
        bus_wdata = fifo_dout;
      end
      default: ;
    endcase
  end

  // Reset overrides the decode so an in-flight access is abandoned immediately
  assign iocs     = bus_cs && !rst;
  assign iorw     = bus_rw || rst;
  assign ioaddr   = rst ? ADDR_BUF : bus_addr;
  assign databus  = (bus_drv && !rst) ? bus_wdata : 8'hzz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Self-checking bench for spart_bus_ctrl: directed scenarios plus a randomized run against a
// transaction-level model (queue of accepted bytes, expected RX strobes).
module tb_spart_bus_ctrl;

  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs, iorw, rx_valid, tx_full, cfg_done;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda = 1'b0, tbr = 1'b0, tx_req = 1'b0;
  logic [7:0] tx_data = '0, rx_data, spart_rd_val = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behaves as the SPART: returns a byte whenever it is read
  assign databus = (iocs && iorw) ? spart_rd_val : 8'hzz;

  spart_bus_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .tx_full (tx_full),
    .cfg_done(cfg_done)
  );

  // Holds reset three cycles and releases it on a falling edge (first config cycle begins)
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rda = 1'b0; tbr = 1'b0; tx_req = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reset_to_idle();
    do_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rda = 1'b0; tbr = 1'b0; tx_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (iocs !== 1'b0) begin n_fail++; $display("FAIL reset_iocs got %b want 0", iocs); end
    n_checks++; if (iorw !== 1'b1) begin n_fail++; $display("FAIL reset_iorw got %b want 1", iorw); end
    n_checks++; if (ioaddr !== 2'b00) begin n_fail++; $display("FAIL reset_ioaddr got %b want 00", ioaddr); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL reset_tx_full got %b want 0", tx_full); end
    n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_done got %b want 0", cfg_done); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if ({iocs, iorw, ioaddr} !== 4'b1010) begin n_fail++; $display("FAIL cfg_lo_ctrl got %b want 1010", {iocs, iorw, ioaddr}); end
    n_checks++; if (databus !== 8'h45) begin n_fail++; $display("FAIL cfg_lo_data got %h want 45", databus); end
    @(negedge clk); #1;
    n_checks++; if ({iocs, iorw, ioaddr} !== 4'b1011) begin n_fail++; $display("FAIL cfg_hi_ctrl got %b want 1011", {iocs, iorw, ioaddr}); end
    n_checks++; if (databus !== 8'h01) begin n_fail++; $display("FAIL cfg_hi_data got %h want 01", databus); end
    n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL cfg_done_early got %b want 0", cfg_done); end
    @(negedge clk); #1;
    n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL cfg_done_set got %b want 1", cfg_done); end
    n_checks++; if (iocs !== 1'b0) begin n_fail++; $display("FAIL idle_iocs got %b want 0", iocs); end
  endtask

  task automatic test_rx();
    logic [7:0] prev_val;
    reset_to_idle();
    @(negedge clk); rda = 1'b1; spart_rd_val = 8'h77; #1;
    n_checks++; if (iocs !== 1'b0) begin n_fail++; $display("FAIL rx_pre_iocs got %b want 0", iocs); end
    @(negedge clk); rda = 1'b0; #1;
    n_checks++; if ({iocs, iorw, ioaddr} !== 4'b1100) begin n_fail++; $display("FAIL rx_read_ctrl got %b want 1100", {iocs, iorw, ioaddr}); end
    @(negedge clk); #1;
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid got %b want 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h77) begin n_fail++; $display("FAIL rx_data got %h want 77", rx_data); end
    n_checks++; if (iocs !== 1'b0) begin n_fail++; $display("FAIL rx_after_iocs got %b want 0", iocs); end
    @(negedge clk); #1;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_width got %b want 0", rx_valid); end
    // Continuous rda: reads every other cycle with one idle between
    prev_val = '0;
    @(negedge clk); rda = 1'b1; #1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      spart_rd_val = 8'($urandom);
      #1;
      if (k % 2 == 1) begin
        n_checks++; if (!(iocs && iorw) || rx_valid) begin n_fail++; $display("FAIL b2b_read k=%0d got cs=%b rw=%b v=%b want read", k, iocs, iorw, rx_valid); end
        prev_val = spart_rd_val;
      end else begin
        n_checks++; if (iocs || !rx_valid || rx_data !== prev_val) begin n_fail++; $display("FAIL b2b_strobe k=%0d got cs=%b v=%b d=%h want 0 1 %h", k, iocs, rx_valid, rx_data, prev_val); end
      end
    end
    rda = 1'b0;
  endtask

  task automatic test_rx_cfg();
    int read_cyc = 0, valid_cyc = 0;
    logic [7:0] got = '0;
    @(negedge clk);
    rst = 1'b1; rda = 1'b0; tbr = 1'b0; tx_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rda = 1'b1; spart_rd_val = 8'h6A;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (read_cyc != 0) rda = 1'b0;
      #1;
      if (iocs && iorw && read_cyc == 0) read_cyc = cyc;
      if (rx_valid && valid_cyc == 0) begin valid_cyc = cyc; got = rx_data; end
    end
    n_checks++; if (read_cyc != 4) begin n_fail++; $display("FAIL cfg_rx_read_cycle got %0d want 4", read_cyc); end
    n_checks++; if (valid_cyc != 5) begin n_fail++; $display("FAIL cfg_rx_valid_cycle got %0d want 5", valid_cyc); end
    n_checks++; if (got !== 8'h6A) begin n_fail++; $display("FAIL cfg_rx_data got %h want 6a", got); end
  endtask

  task automatic test_tx_fifo();
    logic [7:0] vals [4];
    logic [7:0] seen [8];
    int         when [8];
    int         nw = 0;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    reset_to_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); tx_req = 1'b1; tx_data = vals[i]; #1;
      n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL fill_tx_full i=%0d got %b want 0", i, tx_full); end
    end
    @(negedge clk); tx_data = 8'h55; #1;
    n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b want 1", tx_full); end
    @(negedge clk); tx_req = 1'b0; tbr = 1'b1; #1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk); #1;
      if (iocs && !iorw && ioaddr == 2'b00 && nw < 8) begin seen[nw] = databus; when[nw] = cyc; nw++; end
    end
    n_checks++; if (nw != 4) begin n_fail++; $display("FAIL drain_count got %0d want 4", nw); end
    for (int i = 0; i < 4 && i < nw; i++) begin
      n_checks++; if (seen[i] !== vals[i] || when[i] != 1 + 3 * i) begin n_fail++; $display("FAIL drain_%0d got %h@%0d want %h@%0d", i, seen[i], when[i], vals[i], 1 + 3 * i); end
    end
    n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL drained_tx_full got %b want 0", tx_full); end
    tbr = 1'b0;
  endtask

  task automatic test_priority();
    reset_to_idle();
    @(negedge clk); tx_req = 1'b1; tx_data = 8'hA5; #1;
    @(negedge clk); tx_req = 1'b0; rda = 1'b1; tbr = 1'b1; spart_rd_val = 8'h3C; #1;
    n_checks++; if (iocs !== 1'b0) begin n_fail++; $display("FAIL prio_idle got %b want 0", iocs); end
    @(negedge clk); rda = 1'b0; #1;
    n_checks++; if (!(iocs && iorw)) begin n_fail++; $display("FAIL prio_rx_first got cs=%b rw=%b want 1 1", iocs, iorw); end
    @(negedge clk); #1;
    n_checks++; if (iocs || !rx_valid || rx_data !== 8'h3C) begin n_fail++; $display("FAIL prio_rx_data got cs=%b v=%b d=%h want 0 1 3c", iocs, rx_valid, rx_data); end
    @(negedge clk); #1;
    n_checks++; if (!iocs || iorw || databus !== 8'hA5) begin n_fail++; $display("FAIL prio_tx_next got cs=%b rw=%b d=%h want 1 0 a5", iocs, iorw, databus); end
    @(negedge clk); tbr = 1'b0; #1;
    n_checks++; if (iocs !== 1'b0) begin n_fail++; $display("FAIL tx_hold_iocs got %b want 0", iocs); end
  endtask

  task automatic test_echo();
    logic [7:0] exp_byte;
    logic       exp_full;
    logic [7:0] got = '0;
    int         nw = 0;
`ifdef SPART_RX_ECHO_EN
    exp_full = 1'b1; exp_byte = 8'h6A;
`else
    exp_full = 1'b0; exp_byte = 8'h99;
`endif
    reset_to_idle();
    @(negedge clk); rda = 1'b1; spart_rd_val = 8'h6A; #1;
    @(negedge clk); rda = 1'b0; #1;
    @(negedge clk); tx_req = 1'b1; tx_data = 8'h99; #1;
    n_checks++; if (rx_valid !== 1'b1 || tx_full !== exp_full) begin n_fail++; $display("FAIL echo_full got v=%b full=%b want 1 %b", rx_valid, tx_full, exp_full); end
    @(negedge clk); tx_req = 1'b0; tbr = 1'b1; #1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk); #1;
      if (iocs && !iorw) begin nw++; got = databus; end
    end
    n_checks++; if (nw != 1 || got !== exp_byte) begin n_fail++; $display("FAIL echo_write got n=%0d d=%h want 1 %h", nw, got, exp_byte); end
    tbr = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [7:0] got = '0;
    int         nw = 0;
    reset_to_idle();
    @(negedge clk); tx_req = 1'b1; tx_data = 8'hC3;
    @(negedge clk); tx_data = 8'h5A;
    @(negedge clk); tx_req = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; tx_req = 1'b1; tx_data = 8'hE7; #1;
    n_checks++; if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'h45) begin n_fail++; $display("FAIL reprog got ctrl=%b d=%h want 1010 45", {iocs, iorw, ioaddr}, databus); end
    n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reprog_cfg_done got %b want 0", cfg_done); end
    @(negedge clk); tx_req = 1'b0;
    @(negedge clk); tbr = 1'b1; #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk); #1;
      if (iocs && !iorw) begin nw++; got = databus; end
    end
    n_checks++; if (nw != 1 || got !== 8'hE7) begin n_fail++; $display("FAIL flush_early_push got n=%0d d=%h want 1 e7", nw, got); end
    tbr = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic       rd_prev = 1'b0, prev_iocs = 1'b0, prev_tbr = 1'b0, exp_full;
    logic [7:0] rd_prev_val = '0;
    int         pre_size;
    int         local_fail = 0;
    reset_to_idle();
    for (int cyc = 0; cyc < 1540; cyc++) begin
      @(negedge clk);
      if (cyc < 1500) begin
        rda    = ($urandom_range(0, 4) == 0);
        tbr    = $urandom_range(0, 1) == 1;
        tx_req = ($urandom_range(0, 9) < 4);
      end else begin
        rda = 1'b0; tbr = 1'b1; tx_req = 1'b0;
      end
      tx_data      = 8'($urandom);
      spart_rd_val = 8'($urandom);
      #1;
      pre_size = q.size();
      exp_full = (pre_size == Depth);
`ifdef SPART_RX_ECHO_EN
      exp_full = exp_full || rd_prev;
`endif
      n_checks++; if (rx_valid !== rd_prev || (rd_prev && rx_data !== rd_prev_val)) begin n_fail++; local_fail++; $display("FAIL rand_rx cyc=%0d got v=%b d=%h want %b %h", cyc, rx_valid, rx_data, rd_prev, rd_prev_val); end
      n_checks++; if (tx_full !== exp_full) begin n_fail++; local_fail++; $display("FAIL rand_tx_full cyc=%0d got %b want %b", cyc, tx_full, exp_full); end
      n_checks++; if (iocs && prev_iocs) begin n_fail++; local_fail++; $display("FAIL rand_spacing cyc=%0d got back-to-back iocs want gap", cyc); end
      if (iocs && !iorw) begin
        n_checks++;
        if (q.size() == 0 || ioaddr !== 2'b00 || !prev_tbr) begin
          n_fail++; local_fail++;
          $display("FAIL rand_write cyc=%0d got addr=%b qsize=%0d tbr_prev=%b want 00 >0 1", cyc, ioaddr, q.size(), prev_tbr);
        end else begin
          logic [7:0] exp_b;
          exp_b = q.pop_front();
          if (databus !== exp_b) begin n_fail++; local_fail++; $display("FAIL rand_wdata cyc=%0d got %h want %h", cyc, databus, exp_b); end
        end
      end
`ifdef SPART_RX_ECHO_EN
      if (rd_prev) begin
        if (pre_size < Depth) q.push_back(rd_prev_val);
      end else
`endif
      if (tx_req && !exp_full) q.push_back(tx_data);
      rd_prev     = iocs && iorw;
      rd_prev_val = spart_rd_val;
      prev_iocs   = iocs;
      prev_tbr    = tbr;
      if (local_fail > 10) begin
        $display("FAIL rand_abort cyc=%0d got %0d errors want 0", cyc, local_fail);
        break;
      end
    end
    n_checks++; if (q.size() != 0 || tx_full !== 1'b0) begin n_fail++; $display("FAIL rand_drain got qsize=%0d full=%b want 0 0", q.size(), tx_full); end
    tbr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rx();
    test_rx_cfg();
    test_tx_fifo();
    test_priority();
    test_echo();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
